hough_vote_engine: RTL and testbench

HOUGH_VOTE_ENGINE -- requirements
Module: hough_vote_engine

---
 rtl/hough_pkg.sv | 25 ++
 rtl/edge_frame_buf.sv | 24 ++
 rtl/hough_vote_engine.sv | 123 ++++++++++++
 tb/tb_hough_vote_engine.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hough_pkg.sv
// hough_pkg: one-hot state encoding, default geometry and width helper shared by the Hough vote engine.
package hough_pkg;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int BEAT_W_DEF = 240;
  localparam int N_THETA_DEF = 180;
  localparam int RHO_W_DEF = 11;
  localparam int RHO_OFFSET_DEF = 800;
  localparam int ACC_DEPTH_DEF = 1600;
  localparam logic [7:0] S_IDLE = 8'h01;
  localparam logic [7:0] S_LOAD = 8'h02;
  localparam logic [7:0] S_CLEAR = 8'h04;
  localparam logic [7:0] S_FETCH = 8'h08;
  localparam logic [7:0] S_TEST = 8'h10;
  localparam logic [7:0] S_CALC = 8'h20;
  localparam logic [7:0] S_VOTE = 8'h40;
  localparam logic [7:0] S_DONE = 8'h80;
  // Never returns less than 1 so every derived port keeps a legal width.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/edge_frame_buf.sv
// edge_frame_buf: one-bit-per-pixel frame store, written a beat at a time, read one pixel per cycle.
module edge_frame_buf
  import hough_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF * IMG_H_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  localparam int N_BEATS = DEPTH / BEAT_W,
  localparam int BW = clog2(N_BEATS),
  localparam int AW = clog2(DEPTH),
  localparam int IW = clog2(BEAT_W)
) (
  input logic clock,
  input logic wr_en,
  input logic [BW-1:0] wr_beat,
  input logic [BEAT_W-1:0] wr_data,
  input logic [AW-1:0] rd_addr,
  output logic rd_bit
);
  logic [BEAT_W-1:0] mem [N_BEATS];
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_beat] <= wr_data;
    rd_bit <= mem[BW'(rd_addr / AW'(BEAT_W))][IW'(rd_addr % AW'(BEAT_W))];
  end
endmodule

// File: rtl/hough_vote_engine.sv
// hough_vote_engine: buffers an edge frame, clears the accumulator, then votes once per edge pixel and theta step.
module hough_vote_engine
  import hough_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int N_THETA = N_THETA_DEF,
  parameter int RHO_W = RHO_W_DEF,
  parameter int RHO_OFFSET = RHO_OFFSET_DEF,
  parameter int ACC_DEPTH = ACC_DEPTH_DEF,
  localparam int XW = clog2(IMG_W),
  localparam int YW = clog2(IMG_H),
  localparam int TW = clog2(N_THETA),
  localparam int VW = clog2(ACC_DEPTH),
  localparam int PIX = IMG_W * IMG_H,
  localparam int PW = clog2(PIX),
  localparam int N_BEATS = PIX / BEAT_W,
  localparam int BW = clog2(N_BEATS)
) (
  input logic clock,
  input logic reset,
  input logic in_valid,
  input logic [BEAT_W-1:0] in_data,
  output logic in_ready,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [TW-1:0] theta_out,
  input logic signed [RHO_W-1:0] rho_in,
  output logic vote_we,
  output logic vote_clr,
  output logic [VW-1:0] vote_addr,
  output logic busy,
  output logic done,
  output logic rho_oor
);
  logic [7:0] state;
  logic [BW-1:0] beat_idx;
  logic [VW-1:0] clr_cnt;
  logic [PW-1:0] pix;
  logic rd_bit;
  logic signed [RHO_W:0] addr;
  logic in_range, last_beat, last_bin, last_x, last_pix, last_theta, adv;

  edge_frame_buf #(.DEPTH(PIX), .BEAT_W(BEAT_W)) u_buf (
    .clock,
    .wr_en(in_valid && in_ready),
    .wr_beat(beat_idx),
    .wr_data(in_data),
    .rd_addr(pix),
    .rd_bit
  );

  // Sign-extend before biasing so negative rho lands in the out-of-range half.
  assign addr = {rho_in[RHO_W-1], rho_in} + (RHO_W+1)'(RHO_OFFSET);
  assign in_range = !addr[RHO_W] && ({1'b0, addr[RHO_W-1:0]} < (RHO_W+1)'(ACC_DEPTH));
  assign last_beat = beat_idx == BW'(N_BEATS - 1);
  assign last_bin = clr_cnt == VW'(ACC_DEPTH - 1);
  assign last_x = x_out == XW'(IMG_W - 1);
  assign last_pix = last_x && y_out == YW'(IMG_H - 1);
  assign last_theta = theta_out == TW'(N_THETA - 1);
  assign adv = (state == S_TEST && !rd_bit) || (state == S_VOTE && last_theta);

  assign in_ready = state == S_IDLE || state == S_LOAD;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign vote_clr = state == S_CLEAR;
  assign vote_we = state == S_VOTE && in_range;
  assign vote_addr = vote_clr ? clr_cnt : vote_we ? addr[VW-1:0] : '0;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      beat_idx <= '0;
      clr_cnt <= '0;
      pix <= '0;
      x_out <= '0;
      y_out <= '0;
      theta_out <= '0;
      rho_oor <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          state <= S_LOAD;
          beat_idx <= BW'(1);
          rho_oor <= 1'b0;
        end
        S_LOAD: if (in_valid) begin
          beat_idx <= last_beat ? '0 : beat_idx + BW'(1);
          state <= last_beat ? S_CLEAR : S_LOAD;
        end
        S_CLEAR: begin
          clr_cnt <= last_bin ? '0 : clr_cnt + VW'(1);
          state <= last_bin ? S_FETCH : S_CLEAR;
          if (last_bin) begin
            x_out <= '0;
            y_out <= '0;
            pix <= '0;
          end
        end
        S_FETCH: state <= S_TEST;
        S_TEST: if (rd_bit) begin
          state <= S_CALC;
          theta_out <= '0;
        end
        S_CALC: state <= S_VOTE;
        S_VOTE: begin
          rho_oor <= rho_oor || !in_range;
          if (!last_theta) begin
            theta_out <= theta_out + TW'(1);
            state <= S_CALC;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (adv) begin
        x_out <= last_x ? '0 : x_out + XW'(1);
        y_out <= last_x ? y_out + YW'(1) : y_out;
        pix <= pix + PW'(1);
        state <= last_pix ? S_DONE : S_FETCH;
      end
    end
endmodule

// File: tb/tb_hough_vote_engine.sv
// tb_hough_vote_engine: table vectors, reset/hold corner sequences and random frames against a vote-list model.
module tb_hough_vote_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, vote_we, vote_clr, busy, done, rho_oor;
  logic [2:0] x_out;
  logic [1:0] y_out, theta_out;
  logic [3:0] vote_addr;
  logic signed [10:0] rho_in = '0;

  int mode = 0;
  int lut [32][4];
  int checks = 0, errors = 0;
  int cyc = 0, clr_n = 0, clr_bad = 0, both_n = 0, done_n = 0, last_clr = 0, done_cyc = 0;
  int obs[$];
  int exp_q[$];
  bit exp_oor;
  int edges;

  typedef struct {
    logic [31:0] frame;
    int mode;
    bit gap;
    bit hold;
    int nv;
    int sum;
    bit oor;
    int scan;
  } vec_t;
  vec_t vt [7];

  hough_vote_engine #(
    .IMG_W(8), .IMG_H(4), .BEAT_W(8), .N_THETA(4),
    .RHO_W(11), .RHO_OFFSET(8), .ACC_DEPTH(16)
  ) dut (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .x_out(x_out), .y_out(y_out), .theta_out(theta_out), .rho_in(rho_in),
    .vote_we(vote_we), .vote_clr(vote_clr), .vote_addr(vote_addr),
    .busy(busy), .done(done), .rho_oor(rho_oor)
  );

  always #5 clk = ~clk;

  function automatic int rho_fn(input int m, input int x, input int y, input int t);
    if (m == 2) return lut[y * 8 + x][t];
    if (m == 1 && t == 1) return -9;
    return x + t;
  endfunction

  // External rho calculator: answer appears one cycle after the coordinates.
  always @(posedge clk) rho_in <= 11'(rho_fn(mode, int'(x_out), int'(y_out), int'(theta_out)));

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (vote_we) obs.push_back(int'(vote_addr));
    if (vote_clr) begin
      if (int'(vote_addr) != clr_n % 16) clr_bad <= clr_bad + 1;
      clr_n <= clr_n + 1;
      last_clr <= cyc;
    end
    if (vote_we && vote_clr) both_n <= both_n + 1;
    if (done) begin
      done_n <= done_n + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic model(input logic [31:0] frame);
    exp_q.delete();
    exp_oor = 0;
    edges = 0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        if (frame[y * 8 + x]) begin
          edges++;
          for (int t = 0; t < 4; t++) begin
            int a;
            a = rho_fn(mode, x, y, t) + 8;
            if (a >= 0 && a < 16) exp_q.push_back(a);
            else exp_oor = 1;
          end
        end
  endtask

  task automatic run_frame(input logic [31:0] frame, input bit gap, input bit hold, input string tag);
    int o0, c0, b0, w0, d0, ir_bad;
    bit got;
    o0 = obs.size(); c0 = clr_n; b0 = clr_bad; w0 = both_n; d0 = done_n; ir_bad = 0; got = 0;
    model(frame);
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1;
      in_data = frame[b * 8 +: 8];
      @(negedge clk);
      if (gap) begin
        in_valid = 1'b0;
        in_data = 8'hFF;
        @(negedge clk);
      end
    end
    in_valid = hold;
    in_data = 8'hFF;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (in_ready) ir_bad++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, " done_seen"}, int'(got), 1);
    chk({tag, " done_pulses"}, done_n - d0, 1);
    chk({tag, " clear_bins"}, clr_n - c0, 16);
    chk({tag, " clear_order"}, clr_bad - b0, 0);
    chk({tag, " we_clr_overlap"}, both_n - w0, 0);
    chk({tag, " ready_low_after_load"}, ir_bad, 0);
    chk({tag, " n_votes"}, obs.size() - o0, exp_q.size());
    for (int i = 0; i < exp_q.size() && o0 + i < obs.size(); i++)
      chk($sformatf("%s vote_addr[%0d]", tag, i), obs[o0 + i], exp_q[i]);
    chk({tag, " scan_cycles"}, done_cyc - last_clr, 65 + 8 * edges);
    chk({tag, " rho_oor"}, int'(rho_oor), int'(exp_oor));
    chk({tag, " idle_busy_ready"}, int'({busy, in_ready}), 1);
  endtask

  initial begin
    int o0, s, n;
    vt[0] = '{32'h0000_0000, 0, 1'b0, 1'b0, 0, 0, 1'b0, 65};
    vt[1] = '{32'h0008_0000, 0, 1'b0, 1'b0, 4, 50, 1'b0, 73};
    vt[2] = '{32'h0008_0000, 0, 1'b1, 1'b0, 4, 50, 1'b0, 73};
    vt[3] = '{32'h0008_0000, 1, 1'b0, 1'b0, 3, 38, 1'b1, 73};
    vt[4] = '{32'h8000_0000, 0, 1'b0, 1'b0, 1, 15, 1'b1, 73};
    vt[5] = '{32'h0008_0000, 0, 1'b0, 1'b1, 4, 50, 1'b0, 73};
    vt[6] = '{32'h0000_0001, 0, 1'b1, 1'b0, 4, 38, 1'b0, 73};

    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset vote_we_clr", int'({vote_we, vote_clr}), 0);
    chk("reset vote_addr", int'(vote_addr), 0);
    chk("reset rho_oor", int'(rho_oor), 0);
    chk("reset coords", int'({x_out, y_out, theta_out}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release in_ready", int'(in_ready), 1);

    for (int i = 0; i < 7; i++) begin
      o0 = obs.size();
      s = 0;
      mode = vt[i].mode;
      run_frame(vt[i].frame, vt[i].gap, vt[i].hold, $sformatf("vec%0d", i));
      for (int k = o0; k < obs.size(); k++) s += obs[k];
      chk($sformatf("vec%0d tbl_votes", i), obs.size() - o0, vt[i].nv);
      chk($sformatf("vec%0d tbl_addr_sum", i), s, vt[i].sum);
      chk($sformatf("vec%0d tbl_oor", i), int'(rho_oor), int'(vt[i].oor));
      chk($sformatf("vec%0d tbl_scan", i), done_cyc - last_clr, vt[i].scan);
    end

    // Reset in the middle of a VOTE cycle of an all-edge frame.
    mode = 1;
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1;
      in_data = 8'hFF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 500 && n < 5; i++) begin
      @(negedge clk);
      if (vote_we) n++;
    end
    chk("midrst reached_vote", n, 5);
    chk("midrst oor_before", int'(rho_oor), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst vote_we", int'(vote_we), 0);
    chk("midrst vote_addr", int'(vote_addr), 0);
    chk("midrst rho_oor", int'(rho_oor), 0);
    chk("midrst coords", int'({x_out, y_out, theta_out}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst in_ready", int'(in_ready), 1);
    mode = 0;
    run_frame(32'h0008_0000, 1'b0, 1'b0, "post_reset");

    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 32; p++)
        for (int t = 0; t < 4; t++) lut[p][t] = int'($urandom_range(0, 24)) - 12;
      mode = 2;
      run_frame($urandom & $urandom, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
